ss_movavg_mc: RTL and testbench
===============================

# ss_movavg_mc

Multi-channel moving-average estimator for stochastic bit-streams. Each of C channels decimates its input stream, keeps a running count of ones over the last W samples (sliding mode) or over consecutive non-overlapping W-sample blocks (block mode), and presents that count as an N-bit value-estimate. The running count updates incrementally, by adding the new bit and subtracting the expiring bit, so no wide combinational adder tree is needed. The block sits at the output side of stochastic layers. It converts neuron/weight streams into binary values for readout, loss evaluation and debug.

## Interface
- C, 4: number of independent channels
- W, 256: window depth in samples (≥2)
- N, 16: output width per channel; must satisfy N ≥ clog2(W+1); count zero-extended to N
- F_sampling, 5: decimation; one sample taken every F_sampling+1 enabled clocks (0 = every clock)
- MODE, 0: 0 = sliding window, 1 = block (non-overlapping) window

- CLK  in  1  clock, all state on rising edge
- INIT  in  1  reset; synchronous, active-high
- EN  in  1  clock enable for decimation counter and sampling
- IN  in  C  one stochastic bit per channel, IN[c] for channel c
- AVG  out  C*N  per-channel count, channel c at AVG[c*N +: N]
- VALID  out  1  high once first full window/block has been accumulated
- SAMPLE  out  1  one-cycle strobe: AVG was updated on the preceding edge

## Operation
- Reset: INIT=1 at an edge clears the following to 0: decimation counter, fill counter, all window buffers, all counts, AVG, VALID and SAMPLE. INIT has priority over EN. Buffers reset to all-zeros.
- Decimation counter, width clog2(F_sampling+1) (min 1):
  - While EN=1, it counts 0..F_sampling.
  - The edge where it equals F_sampling with EN=1 is a sample tick; the counter wraps to 0 on that edge.
  - EN=0 freezes the counter, buffers, counts and fill counter. SAMPLE is 0 during EN=0.
- Sliding mode (MODE=0), at each tick, per channel:
  - A W-bit shift register shifts IN[c] in and drops the oldest bit o[c].
  - count[c] <= count[c] + IN[c] − o[c]. Count is internally clog2(W+1) bits and always stays in 0..W.
  - AVG is the count register itself, zero-extended. SAMPLE is asserted every tick.
  - The fill counter saturates at W. VALID sets on the tick that brings it to W and stays high until INIT.
  - Before VALID, AVG is the count of ones over the samples taken so far; the zero-filled buffer makes expiring bits 0.
- Block mode (MODE=1): no shift buffer is instantiated. Per channel, acc[c] counts ones at each tick. The sample index runs 0..W−1.
  - On the tick with index W−1:
    - AVG[c] <= acc[c] + IN[c].
    - acc[c] <= 0.
    - Index wraps to 0.
    - SAMPLE asserts.
    - VALID sets, sticky.
  - On other ticks, AVG holds and SAMPLE stays 0.
- Channels are fully independent; they share only the decimation counter, fill/index counter, SAMPLE and VALID.

## Timing
- First tick after INIT deasserts occurs on the (F_sampling+1)th edge with EN=1.
- IN is sampled only on tick edges; IN values between ticks are ignored.
- Latency is one edge: AVG reflects the tick's IN immediately after that edge. SAMPLE is high for exactly the cycle following the edge.
- Sliding mode: VALID rises together with the SAMPLE of the W-th tick.
- Block mode: VALID rises together with the first block SAMPLE.
- INIT mid-operation: outputs read zero the cycle after. The phase restarts, so the next tick is F_sampling+1 enabled edges later and VALID needs a full W further ticks.
- INIT and a would-be tick on the same edge: INIT wins and no sample is taken.

## Test plan
Bench parameters: C=2, W=4, N=8, F_sampling=1 unless noted.
- Reset: hold INIT 3 cycles with IN=2'b11, EN=1 -> AVG=0, VALID=0, SAMPLE=0 throughout and on the cycle after release.
- Sliding fill: IN=2'b01, EN=1 -> ch0 AVG 1,2,3,4 on ticks every 2 clocks, then holds at 4. ch1 AVG stays 0. VALID rises with the 4th SAMPLE.
- Sliding decay: after fill, IN[0]=0 -> ch0 AVG 3,2,1,0 on successive ticks. Then drive IN[0] with pattern 1,0,0,1 -> AVG 1,1,1,2.
- Enable hold: EN=0 for 7 cycles mid-stream -> AVG, VALID and the decimation phase frozen, SAMPLE=0. The next tick lands exactly where it would have had EN never dropped, counting only enabled edges.
- Block mode: MODE=1, F_sampling=0, IN[0] = 1,1,0,1 then 0,0,0,0 -> SAMPLE only on the 4th and 8th cycles after reset. AVG0 becomes 3 then 0. VALID rises at the 4th cycle.
- Mid-run INIT: with ch0 AVG=3 and VALID=1, pulse INIT one cycle -> next cycle AVG=0, VALID=0. With IN=2'b01, VALID returns only after 4 new ticks (8 enabled clocks).

Source files
------------

// File: rtl/ss_movavg_mc.sv
// rtl/ss_movavg_mc.sv - multi-channel moving-average estimator for stochastic bit-streams
// Counts ones per channel over a sliding or block window of decimated samples.
module ss_movavg_mc #(
  parameter int C          = 4,
  parameter int W          = 256,
  parameter int N          = 16,
  parameter int F_sampling = 5,
  parameter int MODE       = 0
) (
  input  logic           CLK,
  input  logic           INIT,
  input  logic           EN,
  input  logic [C-1:0]   IN,
  output logic [C*N-1:0] AVG,
  output logic           VALID,
  output logic           SAMPLE
);
  localparam int DW = (F_sampling > 0) ? $clog2(F_sampling + 1) : 1;
  localparam int CW = $clog2(W + 1);
  localparam logic [DW-1:0] DEC_LAST = DW'(F_sampling);
  localparam logic [CW-1:0] W_CNT    = CW'(W);
  localparam logic [CW-1:0] W_LAST   = CW'(W - 1);

  logic [DW-1:0] dec_q, dec_d;
  logic [CW-1:0] fill_q, fill_d;
  logic          valid_q, valid_d;
  logic          sample_q, sample_d;
  logic          tick;
  logic          last_idx;
  logic [CW-1:0] cnt_q [C];
  logic [CW-1:0] cnt_d [C];
  logic [CW-1:0] avg_val [C];

  // fill_q is the saturating fill count in sliding mode and the block sample index in block mode
  always_comb begin
    tick     = EN && (dec_q == DEC_LAST);
    last_idx = (fill_q == W_LAST);
    dec_d    = dec_q;
    fill_d   = fill_q;
    valid_d  = valid_q;
    sample_d = 1'b0;
    if (EN) dec_d = tick ? '0 : dec_q + DW'(1);
    if (tick) begin
      if (MODE == 0) begin
        sample_d = 1'b1;
        if (fill_q != W_CNT) fill_d = fill_q + CW'(1);
        if (last_idx) valid_d = 1'b1;
      end else if (last_idx) begin
        fill_d   = '0;
        sample_d = 1'b1;
        valid_d  = 1'b1;
      end else begin
        fill_d = fill_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      dec_q    <= '0;
      fill_q   <= '0;
      valid_q  <= 1'b0;
      sample_q <= 1'b0;
    end else begin
      dec_q    <= dec_d;
      fill_q   <= fill_d;
      valid_q  <= valid_d;
      sample_q <= sample_d;
    end
  end

  if (MODE == 0) begin : g_slide
    logic [W-1:0] sh_q [C];
    logic [W-1:0] sh_d [C];

    // The oldest bit leaves as the new one enters, so the count moves by at most one
    always_comb begin
      for (int c = 0; c < C; c++) begin
        sh_d[c]  = sh_q[c];
        cnt_d[c] = cnt_q[c];
        if (tick) begin
          sh_d[c]  = {sh_q[c][W-2:0], IN[c]};
          cnt_d[c] = cnt_q[c] + CW'(IN[c]) - CW'(sh_q[c][W-1]);
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (INIT) begin
        sh_q  <= '{default: '0};
        cnt_q <= '{default: '0};
      end else begin
        sh_q  <= sh_d;
        cnt_q <= cnt_d;
      end
    end

    assign avg_val = cnt_q;
  end else begin : g_block
    logic [CW-1:0] avg_q [C];
    logic [CW-1:0] avg_d [C];

    always_comb begin
      for (int c = 0; c < C; c++) begin
        cnt_d[c] = cnt_q[c];
        avg_d[c] = avg_q[c];
        if (tick) begin
          if (last_idx) begin
            avg_d[c] = cnt_q[c] + CW'(IN[c]);
            cnt_d[c] = '0;
          end else begin
            cnt_d[c] = cnt_q[c] + CW'(IN[c]);
          end
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (INIT) begin
        avg_q <= '{default: '0};
        cnt_q <= '{default: '0};
      end else begin
        avg_q <= avg_d;
        cnt_q <= cnt_d;
      end
    end

    assign avg_val = avg_q;
  end

  always_comb begin
    AVG = '0;
    for (int c = 0; c < C; c++) AVG[c*N +: N] = N'(avg_val[c]);
  end

  assign VALID  = valid_q;
  assign SAMPLE = sample_q;
endmodule

// File: tb/tb_ss_movavg_mc.sv
// tb/tb_ss_movavg_mc.sv - directed bench for ss_movavg_mc in sliding and block modes
module tb_ss_movavg_mc;
  localparam int C = 2;
  localparam int W = 4;
  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           s_init, s_en, s_valid, s_sample;
  logic [C-1:0]   s_in;
  logic [C*N-1:0] s_avg;
  logic           b_init, b_en, b_valid, b_sample;
  logic [C-1:0]   b_in;
  logic [C*N-1:0] b_avg;

  ss_movavg_mc #(.C(C), .W(W), .N(N), .F_sampling(1), .MODE(0)) u_slide (
    .CLK(clk), .INIT(s_init), .EN(s_en), .IN(s_in),
    .AVG(s_avg), .VALID(s_valid), .SAMPLE(s_sample)
  );

  ss_movavg_mc #(.C(C), .W(W), .N(N), .F_sampling(0), .MODE(1)) u_block (
    .CLK(clk), .INIT(b_init), .EN(b_en), .IN(b_in),
    .AVG(b_avg), .VALID(b_valid), .SAMPLE(b_sample)
  );

  typedef struct {
    logic       init;
    logic       en;
    logic [1:0] in;
    int         a0;
    int         a1;
    logic       v;
    logic       s;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  task automatic add(input logic i, input logic e, input logic [1:0] d,
                     input int a0, input int a1, input logic v, input logic s);
    vec_t r;
    r.init = i; r.en = e; r.in = d; r.a0 = a0; r.a1 = a1; r.v = v; r.s = s;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0d exp=%0d", name, idx, got, exp);
    end
  endtask

  task automatic s_step(input logic i, input logic e, input logic [1:0] d);
    s_init = i; s_en = e; s_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic b_step(input logic i, input logic e, input logic [1:0] d);
    b_init = i; b_en = e; b_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int b_a0 [8];
    int b_a1 [8];
    logic [1:0] b_pat [8];

    s_init = 1'b1; s_en = 1'b1; s_in = 2'b11;
    b_init = 1'b1; b_en = 1'b0; b_in = 2'b00;

    // reset held with ones on the inputs
    repeat (3) add(1, 1, 2'b11, 0, 0, 0, 0);
    // sliding fill, tick every second enabled edge
    add(0, 1, 2'b01, 0, 0, 0, 0); add(0, 1, 2'b01, 1, 0, 0, 1);
    add(0, 1, 2'b01, 1, 0, 0, 0); add(0, 1, 2'b01, 2, 0, 0, 1);
    add(0, 1, 2'b01, 2, 0, 0, 0); add(0, 1, 2'b01, 3, 0, 0, 1);
    add(0, 1, 2'b01, 3, 0, 0, 0); add(0, 1, 2'b01, 4, 0, 1, 1);
    add(0, 1, 2'b01, 4, 0, 1, 0); add(0, 1, 2'b01, 4, 0, 1, 1);
    // decay
    add(0, 1, 2'b00, 4, 0, 1, 0); add(0, 1, 2'b00, 3, 0, 1, 1);
    add(0, 1, 2'b00, 3, 0, 1, 0); add(0, 1, 2'b00, 2, 0, 1, 1);
    add(0, 1, 2'b00, 2, 0, 1, 0); add(0, 1, 2'b00, 1, 0, 1, 1);
    add(0, 1, 2'b00, 1, 0, 1, 0); add(0, 1, 2'b00, 0, 0, 1, 1);
    // pattern 1,0,0,1
    add(0, 1, 2'b01, 0, 0, 1, 0); add(0, 1, 2'b01, 1, 0, 1, 1);
    add(0, 1, 2'b00, 1, 0, 1, 0); add(0, 1, 2'b00, 1, 0, 1, 1);
    add(0, 1, 2'b00, 1, 0, 1, 0); add(0, 1, 2'b00, 1, 0, 1, 1);
    add(0, 1, 2'b01, 1, 0, 1, 0); add(0, 1, 2'b01, 2, 0, 1, 1);
    // enable hold mid-phase: inputs toggled while frozen must be ignored
    add(0, 1, 2'b00, 2, 0, 1, 0);
    repeat (7) add(0, 0, 2'b11, 2, 0, 1, 0);
    add(0, 1, 2'b00, 1, 0, 1, 1);
    // channel independence
    add(0, 1, 2'b10, 1, 0, 1, 0); add(0, 1, 2'b10, 1, 1, 1, 1);
    add(0, 1, 2'b01, 1, 1, 1, 0); add(0, 1, 2'b01, 2, 1, 1, 1);
    add(0, 1, 2'b01, 2, 1, 1, 0); add(0, 1, 2'b01, 2, 1, 1, 1);
    add(0, 1, 2'b01, 2, 1, 1, 0); add(0, 1, 2'b01, 3, 1, 1, 1);
    // mid-run INIT, then a full refill before VALID returns
    add(1, 1, 2'b01, 0, 0, 0, 0);
    add(0, 1, 2'b01, 0, 0, 0, 0); add(0, 1, 2'b01, 1, 0, 0, 1);
    add(0, 1, 2'b01, 1, 0, 0, 0); add(0, 1, 2'b01, 2, 0, 0, 1);
    add(0, 1, 2'b01, 2, 0, 0, 0); add(0, 1, 2'b01, 3, 0, 0, 1);
    add(0, 1, 2'b01, 3, 0, 0, 0); add(0, 1, 2'b01, 4, 0, 1, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      s_step(tbl[i].init, tbl[i].en, tbl[i].in);
      chk("slide_avg0", i, 32'(s_avg[0 +: N]), 32'(tbl[i].a0));
      chk("slide_avg1", i, 32'(s_avg[N +: N]), 32'(tbl[i].a1));
      chk("slide_valid", i, 32'(s_valid), 32'(tbl[i].v));
      chk("slide_sample", i, 32'(s_sample), 32'(tbl[i].s));
    end

    // INIT on the edge that would have been a tick: no sample, phase restarts
    s_step(1, 1, 2'b01);
    s_step(0, 1, 2'b01);
    s_step(1, 1, 2'b01);
    chk("collide_avg0", 0, 32'(s_avg[0 +: N]), 32'd0);
    chk("collide_sample", 0, 32'(s_sample), 32'd0);
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      s_step(0, 1, 2'b01);
      if (s_sample === 1'b1) begin
        n = k;
        break;
      end
    end
    chk("collide_edges_to_tick", 0, 32'(n), 32'd2);
    chk("collide_avg0_after", 0, 32'(s_avg[0 +: N]), 32'd1);

    // block mode, one sample per clock
    s_en = 1'b0;
    b_pat = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
    b_a0  = '{0, 0, 0, 3, 3, 3, 3, 0};
    b_a1  = '{0, 0, 0, 3, 3, 3, 3, 4};
    b_step(1, 1, 2'b11);
    chk("block_reset_avg", 0, 32'(b_avg), 32'd0);
    chk("block_reset_valid", 0, 32'(b_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      b_step(0, 1, b_pat[k]);
      chk("block_avg0", k, 32'(b_avg[0 +: N]), 32'(b_a0[k]));
      chk("block_avg1", k, 32'(b_avg[N +: N]), 32'(b_a1[k]));
      chk("block_sample", k, 32'(b_sample), (k == 3 || k == 7) ? 32'd1 : 32'd0);
      chk("block_valid", k, 32'(b_valid), (k >= 3) ? 32'd1 : 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
